// File: rtl/envelope_gen_if.sv
// envelope_gen_if: note, sample and envelope status signals of one ADSR voice
interface envelope_gen_if;
    logic       sample_now;
    logic [3:0] note_in;
    logic [3:0] note_out;
    logic [8:0] sample_in;
    logic       done_in;
    logic [8:0] sample_out;
    logic       done_out;
    logic [7:0] env_level;
    logic [2:0] env_state;

    modport master (
        output sample_now, note_in, sample_in, done_in,
        input  note_out, sample_out, done_out, env_level, env_state
    );

    modport slave (
        input  sample_now, note_in, sample_in, done_in,
        output note_out, sample_out, done_out, env_level, env_state
    );
endinterface

// File: rtl/envelope_gen.sv
// envelope_gen: per-voice ADSR envelope holding the note and scaling the soundpath sample
module envelope_gen #(
    parameter int ENV_DIV      = 40,
    parameter int ATTACK_STEP  = 8,
    parameter int DECAY_STEP   = 2,
    parameter int SUSTAIN_LVL  = 192,
    parameter int RELEASE_STEP = 4
) (
    input logic           clk,
    input logic           n_rst,
    envelope_gen_if.slave bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ATTACK  = 3'd1;
    localparam logic [2:0] S_DECAY   = 3'd2;
    localparam logic [2:0] S_SUSTAIN = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    localparam logic [7:0] DIV_LAST = 8'(ENV_DIV - 1);
    localparam logic [8:0] SUS9     = 9'(SUSTAIN_LVL);

    logic [2:0] state_q, state_d;
    logic [7:0] level_q, level_d;
    logic [7:0] div_q, div_d;
    logic [3:0] note_q, note_d;
    logic [8:0] sout_q, sout_d;
    logic       dout_q;

    logic       active, key_start, key_rel, key_retrig, key_resume, key_evt, tick;
    logic [8:0] att_sum, dec_diff, rel_diff, scaled;

    // Key events, envelope tick and 9-bit level arithmetic
    always_comb begin
        active     = (state_q == S_ATTACK) || (state_q == S_DECAY) || (state_q == S_SUSTAIN);
        key_start  = (state_q == S_IDLE) && (bus.note_in != 4'd0);
        key_rel    = active && (bus.note_in == 4'd0);
        key_retrig = active && (bus.note_in != 4'd0) && (bus.note_in != note_q);
        key_resume = (state_q == S_RELEASE) && (bus.note_in != 4'd0);
        key_evt    = key_start || key_rel || key_retrig || key_resume;
        tick       = bus.sample_now && (div_q == DIV_LAST);
        att_sum    = {1'b0, level_q} + 9'(ATTACK_STEP);
        dec_diff   = {1'b0, level_q} - 9'(DECAY_STEP);
        rel_diff   = {1'b0, level_q} - 9'(RELEASE_STEP);
        div_d      = key_start ? 8'd0 : !bus.sample_now ? div_q : tick ? 8'd0 : div_q + 8'd1;
        scaled     = 9'((17'(bus.sample_in) * (17'(level_q) + 17'd1)) >> 8);
        sout_d     = !bus.done_in ? sout_q : (state_q == S_IDLE) ? 9'd0 : scaled;
    end

    // Next state, level and held note; key events take priority over ticks
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        note_d  = note_q;
        if (key_start || key_retrig || key_resume) begin
            state_d = S_ATTACK;
            note_d  = bus.note_in;
        end else if (key_rel) begin
            state_d = S_RELEASE;
        end else if (tick) begin
            if (state_q == S_ATTACK) begin
                level_d = (att_sum >= 9'd255) ? 8'd255 : att_sum[7:0];
                state_d = (att_sum >= 9'd255) ? S_DECAY : S_ATTACK;
            end else if (state_q == S_DECAY) begin
                level_d = (dec_diff[8] || dec_diff <= SUS9) ? SUS9[7:0] : dec_diff[7:0];
                state_d = (dec_diff[8] || dec_diff <= SUS9) ? S_SUSTAIN : S_DECAY;
            end else if (state_q == S_RELEASE) begin
                level_d = (rel_diff[8] || rel_diff == 9'd0) ? 8'd0 : rel_diff[7:0];
                state_d = (rel_diff[8] || rel_diff == 9'd0) ? S_IDLE : S_RELEASE;
                note_d  = (rel_diff[8] || rel_diff == 9'd0) ? 4'd0 : note_q;
            end
        end
    end

    // Register update with asynchronous clear of all envelope and sample state
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            level_q <= 8'd0;
            div_q   <= 8'd0;
            note_q  <= 4'd0;
            sout_q  <= 9'd0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            div_q   <= div_d;
            note_q  <= note_d;
            sout_q  <= sout_d;
            dout_q  <= bus.done_in;
        end
    end

    assign bus.note_out   = note_q;
    assign bus.sample_out = sout_q;
    assign bus.done_out   = dout_q;
    assign bus.env_level  = level_q;
    assign bus.env_state  = state_q;
endmodule

// File: tb/tb_envelope_gen.sv
// tb_envelope_gen: directed ADSR envelope checks on a fast (ENV_DIV=1) and a divided (ENV_DIV=4) voice
module tb_envelope_gen;
    logic clk;
    logic n_rst;
    int   n_cmp;
    int   n_err;

    envelope_gen_if if1 ();
    envelope_gen_if if4 ();

    envelope_gen #(.ENV_DIV(1)) u1 (.clk(clk), .n_rst(n_rst), .bus(if1.slave));
    envelope_gen #(.ENV_DIV(4)) u4 (.clk(clk), .n_rst(n_rst), .bus(if4.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        if1.sample_now = 1'b0; if1.note_in = 4'd0; if1.sample_in = 9'd0; if1.done_in = 1'b0;
        if4.sample_now = 1'b0; if4.note_in = 4'd0; if4.sample_in = 9'd0; if4.done_in = 1'b0;
        step(2);
        n_cmp++; if (if1.env_state !== 3'd0) begin n_err++; $display("FAIL rst_state got %0d want 0", if1.env_state); end
        n_cmp++; if (if1.env_level !== 8'd0) begin n_err++; $display("FAIL rst_level got %0d want 0", if1.env_level); end
        n_cmp++; if (if1.note_out !== 4'd0) begin n_err++; $display("FAIL rst_note got %0d want 0", if1.note_out); end
        n_cmp++; if (if1.sample_out !== 9'd0) begin n_err++; $display("FAIL rst_sout got %0d want 0", if1.sample_out); end
        n_cmp++; if (if1.done_out !== 1'b0) begin n_err++; $display("FAIL rst_dout got %0d want 0", if1.done_out); end
        n_cmp++; if (if4.env_state !== 3'd0) begin n_err++; $display("FAIL rst_state4 got %0d want 0", if4.env_state); end
        n_rst = 1'b1;
        step(1);
    endtask

    task automatic test_attack;
        if1.note_in = 4'd5;
        if1.sample_now = 1'b1;
        step(1);
        n_cmp++; if (if1.env_state !== 3'd1) begin n_err++; $display("FAIL att_enter_state got %0d want 1", if1.env_state); end
        n_cmp++; if (if1.note_out !== 4'd5) begin n_err++; $display("FAIL att_note got %0d want 5", if1.note_out); end
        n_cmp++; if (if1.env_level !== 8'd0) begin n_err++; $display("FAIL att_enter_level got %0d want 0", if1.env_level); end
        for (int k = 1; k <= 31; k++) begin
            step(1);
            n_cmp++; if (if1.env_level !== 8'(8 * k) || if1.env_state !== 3'd1) begin
                n_err++; $display("FAIL att_tick%0d got level %0d state %0d want %0d state 1", k, if1.env_level, if1.env_state, 8 * k);
            end
        end
        step(1);
        n_cmp++; if (if1.env_level !== 8'd255) begin n_err++; $display("FAIL att_sat_level got %0d want 255", if1.env_level); end
        n_cmp++; if (if1.env_state !== 3'd2) begin n_err++; $display("FAIL att_to_decay got %0d want 2", if1.env_state); end
        if1.sample_now = 1'b0;
    endtask

    task automatic test_sample_full;
        if1.done_in = 1'b1;
        if1.sample_in = 9'd300;
        step(1);
        if1.done_in = 1'b0;
        n_cmp++; if (if1.sample_out !== 9'd300) begin n_err++; $display("FAIL smp255 got %0d want 300", if1.sample_out); end
        n_cmp++; if (if1.done_out !== 1'b1) begin n_err++; $display("FAIL smp255_done got %0d want 1", if1.done_out); end
        step(1);
        n_cmp++; if (if1.done_out !== 1'b0) begin n_err++; $display("FAIL smp255_done_pulse got %0d want 0", if1.done_out); end
        n_cmp++; if (if1.sample_out !== 9'd300) begin n_err++; $display("FAIL smp255_hold got %0d want 300", if1.sample_out); end
    endtask

    task automatic test_decay;
        if1.sample_now = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            step(1);
            n_cmp++; if (if1.env_level !== 8'(255 - 2 * k) || if1.env_state !== 3'd2) begin
                n_err++; $display("FAIL dec_tick%0d got level %0d state %0d want %0d state 2", k, if1.env_level, if1.env_state, 255 - 2 * k);
            end
        end
        step(1);
        n_cmp++; if (if1.env_level !== 8'd192) begin n_err++; $display("FAIL dec_clamp got %0d want 192", if1.env_level); end
        n_cmp++; if (if1.env_state !== 3'd3) begin n_err++; $display("FAIL dec_to_sus got %0d want 3", if1.env_state); end
        step(3);
        n_cmp++; if (if1.env_level !== 8'd192 || if1.env_state !== 3'd3) begin
            n_err++; $display("FAIL sus_hold got level %0d state %0d want 192 state 3", if1.env_level, if1.env_state);
        end
        if1.sample_now = 1'b0;
    endtask

    task automatic test_sample_sustain;
        if1.done_in = 1'b1;
        if1.sample_in = 9'd300;
        step(1);
        if1.done_in = 1'b0;
        n_cmp++; if (if1.sample_out !== 9'd226) begin n_err++; $display("FAIL smp192 got %0d want 226", if1.sample_out); end
        n_cmp++; if (if1.done_out !== 1'b1) begin n_err++; $display("FAIL smp192_done got %0d want 1", if1.done_out); end
    endtask

    task automatic test_release;
        if1.sample_now = 1'b1;
        if1.note_in = 4'd0;
        step(1);
        n_cmp++; if (if1.env_state !== 3'd4) begin n_err++; $display("FAIL rel_enter got %0d want 4", if1.env_state); end
        n_cmp++; if (if1.env_level !== 8'd192) begin n_err++; $display("FAIL rel_enter_level got %0d want 192", if1.env_level); end
        n_cmp++; if (if1.note_out !== 4'd5) begin n_err++; $display("FAIL rel_note_hold got %0d want 5", if1.note_out); end
        for (int k = 1; k <= 47; k++) begin
            step(1);
            n_cmp++; if (if1.env_level !== 8'(192 - 4 * k) || if1.env_state !== 3'd4) begin
                n_err++; $display("FAIL rel_tick%0d got level %0d state %0d want %0d state 4", k, if1.env_level, if1.env_state, 192 - 4 * k);
            end
        end
        step(1);
        n_cmp++; if (if1.env_level !== 8'd0) begin n_err++; $display("FAIL rel_end_level got %0d want 0", if1.env_level); end
        n_cmp++; if (if1.env_state !== 3'd0) begin n_err++; $display("FAIL rel_end_state got %0d want 0", if1.env_state); end
        n_cmp++; if (if1.note_out !== 4'd0) begin n_err++; $display("FAIL rel_end_note got %0d want 0", if1.note_out); end
        if1.sample_now = 1'b0;
    endtask

    task automatic test_sample_idle;
        if1.done_in = 1'b1;
        if1.sample_in = 9'd300;
        step(1);
        if1.done_in = 1'b0;
        n_cmp++; if (if1.sample_out !== 9'd0) begin n_err++; $display("FAIL smp_idle got %0d want 0", if1.sample_out); end
        n_cmp++; if (if1.done_out !== 1'b1) begin n_err++; $display("FAIL smp_idle_done got %0d want 1", if1.done_out); end
    endtask

    task automatic test_resume;
        if1.note_in = 4'd3;
        if1.sample_now = 1'b1;
        step(65);
        n_cmp++; if (if1.env_state !== 3'd3 || if1.env_level !== 8'd192) begin
            n_err++; $display("FAIL resume_setup got level %0d state %0d want 192 state 3", if1.env_level, if1.env_state);
        end
        if1.note_in = 4'd0;
        step(24);
        n_cmp++; if (if1.env_state !== 3'd4 || if1.env_level !== 8'd100) begin
            n_err++; $display("FAIL resume_rel100 got level %0d state %0d want 100 state 4", if1.env_level, if1.env_state);
        end
        if1.note_in = 4'd7;
        step(1);
        n_cmp++; if (if1.env_state !== 3'd1) begin n_err++; $display("FAIL resume_state got %0d want 1", if1.env_state); end
        n_cmp++; if (if1.note_out !== 4'd7) begin n_err++; $display("FAIL resume_note got %0d want 7", if1.note_out); end
        n_cmp++; if (if1.env_level !== 8'd100) begin n_err++; $display("FAIL resume_level got %0d want 100", if1.env_level); end
        step(1);
        n_cmp++; if (if1.env_level !== 8'd108) begin n_err++; $display("FAIL resume_tick got %0d want 108", if1.env_level); end
    endtask

    task automatic test_legato;
        if1.note_in = 4'd5;
        step(1);
        n_cmp++; if (if1.env_state !== 3'd1 || if1.note_out !== 4'd5 || if1.env_level !== 8'd108) begin
            n_err++; $display("FAIL legato_att got state %0d note %0d level %0d want 1 5 108", if1.env_state, if1.note_out, if1.env_level);
        end
        step(19);
        n_cmp++; if (if1.env_state !== 3'd2 || if1.env_level !== 8'd255) begin
            n_err++; $display("FAIL legato_peak got level %0d state %0d want 255 state 2", if1.env_level, if1.env_state);
        end
        step(32);
        n_cmp++; if (if1.env_state !== 3'd3 || if1.env_level !== 8'd192) begin
            n_err++; $display("FAIL legato_sus got level %0d state %0d want 192 state 3", if1.env_level, if1.env_state);
        end
        if1.note_in = 4'd9;
        step(1);
        n_cmp++; if (if1.env_state !== 3'd1) begin n_err++; $display("FAIL retrig_state got %0d want 1", if1.env_state); end
        n_cmp++; if (if1.note_out !== 4'd9) begin n_err++; $display("FAIL retrig_note got %0d want 9", if1.note_out); end
        n_cmp++; if (if1.env_level !== 8'd192) begin n_err++; $display("FAIL retrig_level got %0d want 192", if1.env_level); end
        step(1);
        n_cmp++; if (if1.env_level !== 8'd200) begin n_err++; $display("FAIL retrig_tick got %0d want 200", if1.env_level); end
        if1.sample_now = 1'b0;
    endtask

    task automatic test_div4;
        if4.note_in = 4'd2;
        if4.sample_now = 1'b1;
        step(1);
        n_cmp++; if (if4.env_state !== 3'd1 || if4.env_level !== 8'd0) begin
            n_err++; $display("FAIL div4_enter got state %0d level %0d want 1 0", if4.env_state, if4.env_level);
        end
        for (int k = 1; k <= 3; k++) begin
            step(1);
            n_cmp++; if (if4.env_level !== 8'd0) begin n_err++; $display("FAIL div4_wait%0d got %0d want 0", k, if4.env_level); end
        end
        step(1);
        n_cmp++; if (if4.env_level !== 8'd8) begin n_err++; $display("FAIL div4_tick1 got %0d want 8", if4.env_level); end
        step(3);
        n_cmp++; if (if4.env_level !== 8'd8) begin n_err++; $display("FAIL div4_wait_b got %0d want 8", if4.env_level); end
        step(1);
        n_cmp++; if (if4.env_level !== 8'd16) begin n_err++; $display("FAIL div4_tick2 got %0d want 16", if4.env_level); end
        step(3);
        if4.note_in = 4'd0;
        step(1);
        n_cmp++; if (if4.env_state !== 3'd4) begin n_err++; $display("FAIL div4_rel_state got %0d want 4", if4.env_state); end
        n_cmp++; if (if4.env_level !== 8'd16) begin n_err++; $display("FAIL div4_rel_level got %0d want 16", if4.env_level); end
        step(3);
        n_cmp++; if (if4.env_level !== 8'd16) begin n_err++; $display("FAIL div4_rel_wait got %0d want 16", if4.env_level); end
        step(1);
        n_cmp++; if (if4.env_level !== 8'd12) begin n_err++; $display("FAIL div4_rel_tick got %0d want 12", if4.env_level); end
        if4.sample_now = 1'b0;
    endtask

    task automatic test_reset_mid;
        n_rst = 1'b0;
        step(1);
        n_rst = 1'b1;
        if1.note_in = 4'd4;
        if1.sample_now = 1'b1;
        step(12);
        if1.done_in = 1'b1;
        if1.sample_in = 9'd300;
        step(1);
        if1.done_in = 1'b0;
        if1.sample_now = 1'b0;
        n_cmp++; if (if1.env_level !== 8'd96 || if1.env_state !== 3'd1) begin
            n_err++; $display("FAIL mid_setup got level %0d state %0d want 96 state 1", if1.env_level, if1.env_state);
        end
        n_cmp++; if (if1.sample_out !== 9'd104 || if1.done_out !== 1'b1) begin
            n_err++; $display("FAIL mid_sample got %0d done %0d want 104 done 1", if1.sample_out, if1.done_out);
        end
        #2 n_rst = 1'b0;
        #1;
        n_cmp++; if (if1.env_state !== 3'd0) begin n_err++; $display("FAIL mid_rst_state got %0d want 0", if1.env_state); end
        n_cmp++; if (if1.env_level !== 8'd0) begin n_err++; $display("FAIL mid_rst_level got %0d want 0", if1.env_level); end
        n_cmp++; if (if1.note_out !== 4'd0) begin n_err++; $display("FAIL mid_rst_note got %0d want 0", if1.note_out); end
        n_cmp++; if (if1.sample_out !== 9'd0) begin n_err++; $display("FAIL mid_rst_sout got %0d want 0", if1.sample_out); end
        n_cmp++; if (if1.done_out !== 1'b0) begin n_err++; $display("FAIL mid_rst_dout got %0d want 0", if1.done_out); end
        step(1);
        n_rst = 1'b1;
        if1.note_in = 4'd0;
        if1.sample_now = 1'b1;
        step(5);
        n_cmp++; if (if1.env_state !== 3'd0 || if1.env_level !== 8'd0 || if1.note_out !== 4'd0) begin
            n_err++; $display("FAIL post_rst_idle got state %0d level %0d note %0d want 0 0 0", if1.env_state, if1.env_level, if1.note_out);
        end
        if1.sample_now = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_attack();
        test_sample_full();
        test_decay();
        test_sample_sustain();
        test_release();
        test_sample_idle();
        test_resume();
        test_legato();
        test_div4();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/envelope_gen.md
Name: envelope_gen

Overview:
Per-voice ADSR amplitude envelope placed around each soundpath instance. Takes the selected piano/sequencer note and passes a held note to soundpath, so a voice keeps sounding through release. Scales the soundpath sample by the envelope level and hands the result, with its done strobe, to waveform_comb. Envelope time base is the shared std_rate_clk_div sample_now pulse.

Parameters:
ENV_DIV, 40, envelope steps once per ENV_DIV sample_now pulses; legal range 1..255
ATTACK_STEP, 8, level increment per envelope tick in ATTACK
DECAY_STEP, 2, level decrement per envelope tick in DECAY
SUSTAIN_LVL, 192, sustain level (0..255)
RELEASE_STEP, 4, level decrement per envelope tick in RELEASE

Ports:
clk  in  1  system clock (hwclk)
n_rst  in  1  asynchronous active-low reset
sample_now  in  1  one-cycle sample-rate pulse
note_in  in  4  selected note; 0 = no key
note_out  out  4  held note to soundpath
sample_in  in  9  unsigned sample from soundpath
done_in  in  1  sample_in valid strobe
sample_out  out  9  enveloped sample to waveform_comb
done_out  out  1  sample_out valid strobe
env_level  out  8  current envelope level
env_state  out  3  IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4

Behaviour:
- Reset (async, n_rst=0): state IDLE, level 0, divider 0, note_out 0, sample_out 0, done_out 0.
- Envelope tick: divider counts sample_now pulses; on a pulse with divider==ENV_DIV-1, tick fires and divider <= 0. Divider clears to 0 on the IDLE->ATTACK transition.
- Key events take effect on the next clock edge, regardless of tick:
  - IDLE, note_in!=0: ATTACK; note_out<=note_in; level stays 0.
  - ATTACK/DECAY/SUSTAIN, note_in==0: RELEASE; note_out holds.
  - ATTACK/DECAY/SUSTAIN, note_in!=0 and !=note_out: ATTACK (legato retrigger); note_out<=note_in; level kept.
  - RELEASE, note_in!=0: ATTACK; note_out<=note_in; level kept.
- A key event and a tick in the same cycle: the key event wins; level is not updated that cycle.
- Level updates on tick only, with no key event:
  - ATTACK: level+ATTACK_STEP, saturating at 255; on reaching 255 go to DECAY.
  - DECAY: level-DECAY_STEP, saturating at SUSTAIN_LVL; on reaching it go to SUSTAIN. If level<=SUSTAIN_LVL on entry, the first tick sets level=SUSTAIN_LVL and goes to SUSTAIN.
  - SUSTAIN: level unchanged.
  - RELEASE: level-RELEASE_STEP, saturating at 0; on reaching 0 go to IDLE, note_out<=0 on the same edge.
- Arithmetic: add/subtract at 9 bits, then clamp; 8-bit wrap is never allowed.
- Sample path, 1-cycle latency:
  - On done_in: sample_out <= (sample_in*(level+1))>>8, using the 17-bit product and the level held in that cycle. Forced to 0 when state==IDLE.
  - done_out pulses high for exactly 1 cycle after each done_in.
  - Without done_in: sample_out holds, done_out=0.
  - level 255 passes sample_in unchanged.
- env_level and env_state are direct register outputs.
- Reset mid-operation returns every output to its reset value immediately; no tick is pending afterwards.

Test Plan:
1. Assert n_rst=0 during ATTACK at level 96 -> same cycle: env_state=0, env_level=0, note_out=0, sample_out=0, done_out=0; after release of reset, sample_now pulses with note_in=0 -> stays IDLE.
2. ENV_DIV=1, note_in=5 held, sample_now every cycle -> note_out=5, ATTACK climbs 8/tick, 32nd tick saturates to 255 and enters DECAY. Then 2/tick, 32nd DECAY tick clamps to 192 and enters SUSTAIN; level stays 192.
3. done_in with sample_in=300: at level 255 -> next cycle sample_out=300, done_out=1 for one cycle. At level 192 -> sample_out=226. In IDLE -> sample_out=0.
4. From SUSTAIN level 192, note_in->0 -> RELEASE, note_out stays 5, level drops 4/tick. After 48 ticks level=0, state IDLE, note_out=0.
5. In RELEASE at level 100, note_in=7 -> next edge ATTACK, note_out=7, level 100, next tick 108. In SUSTAIN, note_in 5->9 -> ATTACK from 192, note_out=9.
6. ENV_DIV=4 -> level changes only on every 4th sample_now. Key release coincident with a tick -> RELEASE entered, level unchanged that cycle.
